// File: rtl/rv_pkg.sv
// Shared RV32I decode constants and the decoded-instruction bundle that is
// carried by the decode pipeline register.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [6:0] F7_BASE    = 7'h00;
  localparam logic [6:0] F7_ALT     = 7'h20;  // SUB / SRA

  // a_rs1 / b_rs2 / sd_rs2 mark fields sourced from the register file,
  // so a writeback during a stall can refresh them.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        we;
    logic        is_load;
    logic        is_store;
    logic        illegal;
    logic        a_rs1;
    logic        b_rs2;
    logic        sd_rs2;
  } dec_t;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/rv_regfile.sv
// 32x32 integer register file: two asynchronous read ports, one write port,
// x0 reads as zero and ignores writes.
module rv_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: combinational decode plus operand read feeding one
// valid/ready pipeline register toward execute.
import rv_pkg::*;

module rv_decode_stage #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_is_load,
  output logic        out_is_store,
  output logic [31:0] out_store_data,
  output logic        out_illegal
);

  logic [6:0]  opc;
  logic [4:0]  rs1_a, rs2_a;
  logic [31:0] rf1, rf2, rs1_v, rs2_v;
  logic        wb_live, accept;
  dec_t        dec, q;

  assign opc   = in_instr[6:0];
  assign rs1_a = in_instr[19:15];
  assign rs2_a = in_instr[24:20];

  rv_regfile u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1_a),
    .raddr2 (rs2_a),
    .rdata1 (rf1),
    .rdata2 (rf2)
  );

  assign wb_live = wb_en && (wb_rd != 5'd0);
  assign rs1_v   = (BYPASS_EN && wb_live && wb_rd == rs1_a) ? wb_data : rf1;
  assign rs2_v   = (BYPASS_EN && wb_live && wb_rd == rs2_a) ? wb_data : rf2;

  always_comb begin
    dec        = '0;
    dec.rs1    = rs1_a;
    dec.rs2    = rs2_a;
    dec.rd     = in_instr[11:7];
    dec.funct3 = F3_ADD_SUB;
    dec.funct7 = F7_BASE;
    if (in_instr[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (opc)
        OPC_OP: begin
          dec.a      = rs1_v;
          dec.b      = rs2_v;
          dec.funct3 = in_instr[14:12];
          dec.funct7 = in_instr[31:25];
          dec.we     = 1'b1;
          dec.a_rs1  = 1'b1;
          dec.b_rs2  = 1'b1;
        end
        OPC_OP_IMM: begin
          dec.a      = rs1_v;
          dec.b      = sext12(in_instr[31:20]);
          dec.funct3 = in_instr[14:12];
          // only SRAI carries the alternate encoding; imm bit 30 of ADDI is data
          dec.funct7 = (in_instr[14:12] == F3_SRL_SRA && in_instr[30]) ? F7_ALT : F7_BASE;
          dec.we     = 1'b1;
          dec.a_rs1  = 1'b1;
        end
        OPC_LUI: begin
          dec.b  = {in_instr[31:12], 12'b0};
          dec.we = 1'b1;
        end
        OPC_AUIPC: begin
          dec.a  = in_pc;
          dec.b  = {in_instr[31:12], 12'b0};
          dec.we = 1'b1;
        end
        OPC_LOAD: begin
          dec.a       = rs1_v;
          dec.b       = sext12(in_instr[31:20]);
          dec.is_load = 1'b1;
          dec.we      = 1'b1;
          dec.a_rs1   = 1'b1;
        end
        OPC_STORE: begin
          dec.a          = rs1_v;
          dec.b          = sext12({in_instr[31:25], in_instr[11:7]});
          dec.store_data = rs2_v;
          dec.is_store   = 1'b1;
          dec.a_rs1      = 1'b1;
          dec.sd_rs2     = 1'b1;
          dec.rd         = 5'd0;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
    if (dec.illegal) dec.rd = 5'd0;
    if (dec.rd == 5'd0) dec.we = 1'b0;
  end

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      q         <= dec;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid && wb_live) begin
      // stalled: keep register-sourced operands coherent with the regfile
      if (q.a_rs1  && wb_rd == q.rs1) q.a          <= wb_data;
      if (q.b_rs2  && wb_rd == q.rs2) q.b          <= wb_data;
      if (q.sd_rs2 && wb_rd == q.rs2) q.store_data <= wb_data;
    end
  end

  assign out_a          = q.a;
  assign out_b          = q.b;
  assign out_funct3     = q.funct3;
  assign out_funct7     = q.funct7;
  assign out_rd         = q.rd;
  assign out_we         = q.we;
  assign out_is_load    = q.is_load;
  assign out_is_store   = q.is_store;
  assign out_store_data = q.store_data;
  assign out_illegal    = q.illegal;

endmodule
